bsg_arb_mux_one_hot_rr: RTL and testbench
=========================================

BSG_ARB_MUX_ONE_HOT_RR -- requirements
Module: bsg_arb_mux_one_hot_rr

Interface
REQ-001 SHALL have parameter width_p, default 41, meaning the data width of each element.
REQ-002 SHALL have parameter els_p, default 4, meaning the number of requesters; legal range 1..16.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port v_i, input, els_p bits: per-requester valid.
REQ-006 SHALL have port data_i, input, els_p*width_p bits: requester k data in bits [k*width_p +: width_p].
REQ-007 SHALL have port yumi_o, output, els_p bits: one-hot consume of the granted requester, at most one bit set.
REQ-008 SHALL have port v_o, output, 1 bit: output register holds valid data.
REQ-009 SHALL have port data_o, output, width_p bits: registered selected data.
REQ-010 SHALL have port sel_one_hot_o, output, els_p bits: registered one-hot tag of the source of data_o.
REQ-011 SHALL have port yumi_i, input, 1 bit: downstream consumes data_o this cycle.

Function
REQ-012 SHALL define accept = ~v_o | yumi_i, combinationally.
REQ-013 SHALL compute grant, one-hot or all-zero, from v_i and the priority pointer ptr; grant is all-zero iff v_i is all-zero.
REQ-014 SHALL drive yumi_o = grant when accept is 1, else all-zero; yumi_o SHALL NOT depend on data_i.
REQ-015 SHALL select data with a one-hot AND-OR mux: selected = OR over k of (data_i element k AND grant[k]).
REQ-016 On accept with grant nonzero SHALL load data_o <= selected, sel_one_hot_o <= grant, v_o <= 1 at the next edge; the latency from v_i to v_o is 1 cycle.
REQ-017 On accept with grant zero SHALL set v_o <= 0 and hold data_o and sel_one_hot_o.
REQ-018 When accept is 0 SHALL hold v_o, data_o, sel_one_hot_o and ptr, and SHALL drive yumi_o all-zero (backpressure).
REQ-019 Simultaneous yumi_i and a new grant SHALL both take effect in the same cycle, sustaining 1 transfer per cycle.
REQ-020 yumi_i while v_o=0 SHALL be ignored; the behaviour is identical to yumi_i=0.
REQ-021 ptr SHALL be $clog2(els_p) bits (1 bit minimum); on each transfer, ptr <= granted index + 1, wrapping from els_p-1 to 0.
REQ-022 With els_p=1, grant SHALL equal v_i[0], and ptr SHALL remain at 0.

Reset
REQ-023 While reset_i=1: v_o=0, data_o=0, sel_one_hot_o=0, ptr=0, and yumi_o=0 combinationally.
REQ-024 Reset asserted mid-transfer SHALL discard the held data immediately; no yumi_o SHALL be issued until the first edge after reset_i deasserts.

Configuration
REQ-025 Macro BSG_ARB_MUX_ROUND_ROBIN_EN defined: grant SHALL go to the first set v_i at index ptr, ptr+1, ..., wrapping modulo els_p.
REQ-026 Macro BSG_ARB_MUX_ROUND_ROBIN_EN undefined: grant SHALL be fixed priority with the lowest set index winning, and ptr logic SHALL be removed, with ptr constant 0.

Verification
REQ-027 Reset: reset_i=1 and v_i=4'b1111 -> yumi_o=0, v_o=0, data_o=0; after release, the first edge captures element 0 and sel_one_hot_o=4'b0001.
REQ-028 Round-robin (macro defined), v_i=4'b1111 held, yumi_i=1 -> sel_one_hot_o sequence 0001, 0010, 0100, 1000, 0001, with one transfer per cycle.
REQ-029 Fixed priority (macro undefined), v_i=4'b1010 held -> every transfer has sel_one_hot_o=4'b0010.
REQ-030 Backpressure: v_o=1, yumi_i=0 for 3 cycles with data_i changing -> yumi_o=0, and data_o and sel_one_hot_o are stable.
REQ-031 Drain: v_i=0 and yumi_i=1 at v_o=1 -> v_o=0 on the next cycle; yumi_i at v_o=0 causes no change.
REQ-032 Data integrity, width_p=41: element 2 = 41'h1_5555_AAAA_A, v_i=4'b0100 -> data_o=41'h1_5555_AAAA_A, with no other element's bits ORed in.

Source files
------------

// File: rtl/bsg_arb_mux_one_hot_rr.sv
// bsg_arb_mux_one_hot_rr
//
// Arbitrates among els_p requesters and selects the winner's data through a
// one-hot AND-OR mux. The result goes into a single output register with a
// valid/yumi handshake. The register accepts a new word when it is empty or
// when downstream consumes the current word in the same cycle, so the block
// sustains one transfer per cycle.
//
// Build option:
//   BSG_ARB_MUX_ROUND_ROBIN_EN  defined   -> round-robin arbitration. The
//                                            search starts at ptr and the
//                                            pointer moves past each winner.
//                               undefined -> fixed priority. The lowest set
//                                            index wins and there is no
//                                            pointer.
//
// Parameters:
//   width_p        data width of one element
//   els_p          number of requesters (1..16)
//
// Ports:
//   clk_i          clock; all state updates on the rising edge
//   reset_i        asynchronous, active-high reset
//   v_i            per-requester valid
//   data_i         requester k data in bits [k*width_p +: width_p]
//   yumi_o         one-hot consume of the granted requester
//   v_o            output register holds valid data
//   data_o         registered selected data
//   sel_one_hot_o  registered one-hot tag of the source of data_o
//   yumi_i         downstream consumes data_o this cycle

module bsg_arb_mux_one_hot_rr #(
  parameter int width_p = 41,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   data_i,
  output logic [els_p-1:0]           yumi_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [els_p-1:0]           sel_one_hot_o,
  input  logic                       yumi_i
);

  logic               accept;
  logic [els_p-1:0]   grant;
  logic [width_p-1:0] selected;

  // The output register can take a new word when it is empty or being drained.
  assign accept = ~v_o | yumi_i;

`ifdef BSG_ARB_MUX_ROUND_ROBIN_EN
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [ptr_w_lp-1:0] ptr_r;
  logic [ptr_w_lp-1:0] grant_idx;

  // Walk the requesters starting at ptr, wrapping modulo els_p, and grant the
  // first valid one. The sum ptr+i is at most 2*els_p-2, so a single
  // conditional subtract is enough to wrap it back into range.
  always_comb begin : rr_search
    int                  idx;
    logic                found;
    logic [ptr_w_lp-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < els_p; i++) begin
      idx = int'(ptr_r) + i;
      if (idx >= els_p) idx = idx - els_p;
      cand = ptr_w_lp'(idx);
      if (!found && v_i[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  // The pointer moves one past the winner on every transfer so that the
  // winner gets the lowest priority next time. With els_p=1 the only index is
  // also the last one, so the pointer always wraps back to 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_r <= '0;
    end else if (accept && (|grant)) begin
      if (grant_idx == ptr_w_lp'(els_p - 1))
        ptr_r <= '0;
      else
        ptr_r <= grant_idx + ptr_w_lp'(1);
    end
  end
`else
  // Fixed priority: the lowest-indexed valid requester wins.
  always_comb begin : fixed_search
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      if (!found && v_i[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

  // Reset forces yumi_o low directly. While reset_i is high, v_o is already
  // 0, which makes accept 1, so accept alone would not block a consume.
  assign yumi_o = (accept && !reset_i) ? grant : '0;

  // One-hot AND-OR mux. Only the granted element can contribute bits.
  always_comb begin
    selected = '0;
    for (int k = 0; k < els_p; k++) begin
      selected = selected | (data_i[k*width_p +: width_p] & {width_p{grant[k]}});
    end
  end

  // Output register. It loads the winner on accept and goes empty on accept
  // with no requester. Under backpressure it holds.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_o           <= 1'b0;
      data_o        <= '0;
      sel_one_hot_o <= '0;
    end else if (accept) begin
      if (|grant) begin
        v_o           <= 1'b1;
        data_o        <= selected;
        sel_one_hot_o <= grant;
      end else begin
        v_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bsg_arb_mux_one_hot_rr.sv
// tb_bsg_arb_mux_one_hot_rr
//
// Self-checking bench for bsg_arb_mux_one_hot_rr with the default parameters
// (width_p=41, els_p=4). A reference model written from the arbitration rules
// predicts yumi_o and the output register every cycle. Each predicted
// transfer is queued, and a separate monitor pops an entry whenever
// downstream consumes data_o.

module tb_bsg_arb_mux_one_hot_rr;

  localparam int W = 41;
  localparam int N = 4;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [N-1:0]     v_i;
  logic [N*W-1:0]   data_i;
  logic [N-1:0]     yumi_o;
  logic             v_o;
  logic [W-1:0]     data_o;
  logic [N-1:0]     sel_one_hot_o;
  logic             yumi_i;

  bsg_arb_mux_one_hot_rr #(.width_p(W), .els_p(N)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .v_i           (v_i),
    .data_i        (data_i),
    .yumi_o        (yumi_o),
    .v_o           (v_o),
    .data_o        (data_o),
    .sel_one_hot_o (sel_one_hot_o),
    .yumi_i        (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [W-1:0] data;
    logic [N-1:0] sel;
  } item_t;

  item_t sb_q[$];
  item_t mon_item;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state.
  logic         m_v;
  logic [W-1:0] m_data;
  logic [N-1:0] m_sel;
  int           m_ptr;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns the index that should win for request vector v, or -1 if none.
  function automatic int modelPick(input logic [N-1:0] v);
`ifdef BSG_ARB_MUX_ROUND_ROBIN_EN
    for (int off = 0; off < N; off++) begin
      int k;
      k = (m_ptr + off) % N;
      if (v[k]) return k;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  function automatic logic [N*W-1:0] randData();
    logic [N*W-1:0] r;
    logic [63:0]    t;
    r = '0;
    for (int k = 0; k < N; k++) begin
      t = {$urandom, $urandom};
      r[k*W +: W] = t[W-1:0];
    end
    return r;
  endfunction

  // Drives one cycle of inputs and checks yumi_o before the clock edge. It
  // then advances the model across the edge and checks the registered
  // outputs. The call is made 1 time unit after a posedge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic y);
    int           k;
    logic         acc;
    logic [N-1:0] exp_yumi;
    logic [N*W-1:0] dd;
    v_i    = v;
    data_i = d;
    yumi_i = y;
    #1;
    k   = modelPick(v);
    acc = !m_v || y;
    exp_yumi = (acc && k >= 0) ? (N'(1) << k) : '0;
    checkOutput("yumi_o", yumi_o, exp_yumi);
    if (acc) begin
      if (k >= 0) begin
        dd     = d;
        m_v    = 1'b1;
        m_data = dd[k*W +: W];
        m_sel  = N'(1) << k;
        sb_q.push_back('{data: m_data, sel: m_sel});
`ifdef BSG_ARB_MUX_ROUND_ROBIN_EN
        m_ptr = (k + 1) % N;
`endif
      end else begin
        m_v = 1'b0;
      end
    end
    @(posedge clk_i);
    #1;
    checkOutput("v_o", v_o, m_v);
    checkOutput("data_o", data_o, m_data);
    checkOutput("sel_one_hot_o", sel_one_hot_o, m_sel);
  endtask

  // Asserts reset with every requester valid and checks that the outputs
  // clear at once. It releases reset 1 time unit after the next posedge.
  task automatic doReset();
    reset_i = 1'b1;
    v_i     = '1;
    data_i  = randData();
    yumi_i  = 1'b0;
    #1;
    checkOutput("rst_yumi_o", yumi_o, 0);
    checkOutput("rst_v_o", v_o, 0);
    checkOutput("rst_data_o", data_o, 0);
    checkOutput("rst_sel", sel_one_hot_o, 0);
    @(posedge clk_i);
    #1;
    checkOutput("rst_hold_v_o", v_o, 0);
    checkOutput("rst_hold_yumi_o", yumi_o, 0);
    sb_q.delete();
    m_v     = 1'b0;
    m_data  = '0;
    m_sel   = '0;
    m_ptr   = 0;
    reset_i = 1'b0;
  endtask

  // Scoreboard monitor: every word consumed downstream must match the oldest
  // predicted transfer.
  always @(negedge clk_i) begin
    if (!reset_i && v_o && yumi_i) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL sb_underflow: got data %h, expected no word at %0t", data_o, $time);
      end else begin
        mon_item = sb_q.pop_front();
        checkOutput("sb_data", data_o, mon_item.data);
        checkOutput("sb_sel", sel_one_hot_o, mon_item.sel);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N*W-1:0] d;
    logic [W-1:0]   d0;
    logic [N-1:0]   rv;
    logic           ry;

    reset_i = 1'b1;
    v_i     = '0;
    data_i  = '0;
    yumi_i  = 1'b0;
    m_v = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0;
    @(posedge clk_i);
    #1;

    // Reset with all requesters valid, then the first edge takes element 0.
    doReset();
    d  = randData();
    d0 = d[W-1:0];
    applyStimulus(4'b1111, d, 1'b1);
    checkOutput("first_sel", sel_one_hot_o, 4'b0001);
    checkOutput("first_data", data_o, d0);

`ifdef BSG_ARB_MUX_ROUND_ROBIN_EN
    // All requesting with continuous consume: the grant rotates every cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1111, randData(), 1'b1);
      checkOutput("rr_seq", sel_one_hot_o, N'(1) << ((i + 1) % N));
    end
`else
    // Fixed priority: the lowest set index always wins.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1010, randData(), 1'b1);
      checkOutput("fixed_sel", sel_one_hot_o, 4'b0010);
    end
`endif

    // Backpressure: the register is full and nothing is consumed.
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, randData(), 1'b0);

    // Drain, then check that a consume with nothing held is ignored.
    applyStimulus(4'b0000, randData(), 1'b1);
    applyStimulus(4'b0000, randData(), 1'b1);
    applyStimulus(4'b0000, randData(), 1'b0);

    // Data integrity: the other elements are all ones, so any leaked bit
    // would show up in data_o.
    d = '1;
    d[2*W +: W] = 41'h1_5555_AAAA_A;
    applyStimulus(4'b0100, d, 1'b1);
    checkOutput("integrity", data_o, 41'h1_5555_AAAA_A);

    // Reset while a word is held: it must be discarded.
    applyStimulus(4'b0001, randData(), 1'b1);
    doReset();
    applyStimulus(4'b1111, randData(), 1'b1);
    checkOutput("post_rst_sel", sel_one_hot_o, 4'b0001);

    // Random traffic with mostly-consuming downstream.
    for (int i = 0; i < 400; i++) begin
      rv = 4'($urandom_range(0, 15));
      ry = ($urandom_range(0, 3) != 0);
      applyStimulus(rv, randData(), ry);
    end

    // Final drain: every predicted transfer must have been consumed.
    applyStimulus(4'b0000, randData(), 1'b1);
    applyStimulus(4'b0000, randData(), 1'b1);
    checkOutput("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
